pipelined_control_unit: RTL and testbench

//  Registered, pipeline-aware successor to the combinational main decoder. Decodes the 7-bit RV32I opcode

---
 rtl/riscv_ctrl_pkg.sv | 30 +++
 rtl/opcode_decoder.sv | 38 +++
 rtl/pipelined_control_unit.sv | 91 +++++++++
 tb/tb_pipelined_control_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, alu_op encodings, control bundle and halt FSM states
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_HALT  = 7'b1111111;
  localparam logic [1:0] ALU_LDST = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_RI   = 2'b10;
  localparam logic [1:0] ALU_UJ   = 2'b11;
  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       auipc;
  } ctrl_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_e;
endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational opcode to control bundle with halt/illegal flags
module opcode_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_AUIPC = 1'b1
) (
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);
  // decode table; anything not listed is illegal
  always_comb begin
    ctrl_o = '0;
    is_halt_o = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_R: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_RI; end
      OP_LW: begin ctrl_o.alu_src = 1'b1; ctrl_o.mem_to_reg = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.mem_read = 1'b1; ctrl_o.alu_op = ALU_LDST; end
      OP_SW: begin ctrl_o.alu_src = 1'b1; ctrl_o.mem_write = 1'b1; ctrl_o.alu_op = ALU_LDST; end
      OP_BR: begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_BR; end
      OP_I: begin ctrl_o.alu_src = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_RI; end
      OP_LUI: begin ctrl_o.alu_src = 1'b1; ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_UJ; end
      OP_JAL: begin ctrl_o.reg_write = 1'b1; ctrl_o.branch = 1'b1; ctrl_o.jal = 1'b1; ctrl_o.alu_op = ALU_UJ; end
      OP_JALR: begin ctrl_o.reg_write = 1'b1; ctrl_o.branch = 1'b1; ctrl_o.jal = 1'b1; ctrl_o.jalr = 1'b1; ctrl_o.alu_op = ALU_UJ; end
      OP_AUIPC: begin
        if (ENABLE_AUIPC) begin
          ctrl_o.alu_src = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.auipc = 1'b1;
          ctrl_o.alu_op = ALU_UJ;
        end else is_illegal_o = 1'b1;
      end
      OP_HALT: is_halt_o = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered ID/EX control bundle with stall, flush, illegal trap and halt drain
module pipelined_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES    = 3,
  parameter bit ENABLE_AUIPC    = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid_i,
  input  logic [6:0] opcode_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output ctrl_t      ctrl_o,
  output logic       ctrl_valid_o,
  output logic       illegal_o,
  output logic       fetch_stall_o,
  output logic       halted_o
);
  localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  halt_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t ctrl_q, ctrl_d, dec_ctrl;
  logic ctrl_valid_q, ctrl_valid_d, illegal_q, illegal_d;
  logic fetch_stall_q, fetch_stall_d, halted_q, halted_d;
  logic is_halt, is_illegal;
  opcode_decoder #(.ENABLE_AUIPC(ENABLE_AUIPC)) u_dec (
    .opcode_i    (opcode_i),
    .ctrl_o      (dec_ctrl),
    .is_halt_o   (is_halt),
    .is_illegal_o(is_illegal)
  );
  // next-state: flush > stall > no-instr > decode in RUN; DRAIN and HALTED only emit bubbles
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ctrl_d = '0;
    ctrl_valid_d = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      RUN: begin
        if (!flush_i && stall_i) begin
          ctrl_d = ctrl_q;
          ctrl_valid_d = ctrl_valid_q;
        end else if (!flush_i && instr_valid_i) begin
          illegal_d = is_illegal;
          if (is_halt || (is_illegal && TRAP_ON_ILLEGAL)) begin
            state_d = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
            cnt_d = (DRAIN_CYCLES == 0) ? '0 : CW'(DRAIN_CYCLES - 1);
          end else if (!is_illegal) begin
            ctrl_d = dec_ctrl;
            ctrl_valid_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? HALTED : DRAIN;
      end
      default: state_d = state_q;
    endcase
    fetch_stall_d = state_d != RUN;
    halted_d = state_d == HALTED;
  end
  // ID/EX register, FSM state and drain counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q <= '0;
      ctrl_q <= '0;
      ctrl_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      fetch_stall_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ctrl_q <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      illegal_q <= illegal_d;
      fetch_stall_q <= fetch_stall_d;
      halted_q <= halted_d;
    end
  end
  assign ctrl_o = ctrl_q;
  assign ctrl_valid_o = ctrl_valid_q;
  assign illegal_o = illegal_q;
  assign fetch_stall_o = fetch_stall_q;
  assign halted_o = halted_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: table-driven decode checks plus stall/flush/halt/trap/reset sequences
module tb_pipelined_control_unit;
  import riscv_ctrl_pkg::*;
  typedef struct packed {logic [10:0] c; logic v, ill, fs, h;} exp_t;
  typedef struct {logic [6:0] op; logic [10:0] c;} vec_t;
  localparam logic [10:0] C_R = 11'b00100100000, C_LW = 11'b11110000000, C_SW = 11'b10001000000;
  localparam logic [10:0] C_BR = 11'b00000011000, C_I = 11'b10100100000, C_LUI = 11'b10100110000;
  localparam logic [10:0] C_JAL = 11'b00100111100, C_JALR = 11'b00100111110, C_AU = 11'b10100110001;
  localparam logic [6:0] O_R = 7'b0110011, O_SW = 7'b0100011, O_I = 7'b0010011;
  localparam logic [6:0] O_AU = 7'b0010111, O_HALT = 7'b1111111, O_BAD = 7'b0001011;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [6:0] opcode = '0;
  ctrl_t a_ctrl, b_ctrl;
  logic a_v, a_ill, a_fs, a_h, b_v, b_ill, b_fs, b_h;
  int checks = 0, errors = 0;
  exp_t sb[$];
  vec_t vecs[9];
  always #5 clk = ~clk;
  pipelined_control_unit dut_a (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .opcode_i(opcode), .stall_i(stall),
    .flush_i(flush), .ctrl_o(a_ctrl), .ctrl_valid_o(a_v), .illegal_o(a_ill), .fetch_stall_o(a_fs),
    .halted_o(a_h)
  );
  pipelined_control_unit #(.DRAIN_CYCLES(2), .ENABLE_AUIPC(1'b0), .TRAP_ON_ILLEGAL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .opcode_i(opcode), .stall_i(stall),
    .flush_i(flush), .ctrl_o(b_ctrl), .ctrl_valid_o(b_v), .illegal_o(b_ill), .fetch_stall_o(b_fs),
    .halted_o(b_h)
  );
  function automatic exp_t ex(logic [10:0] c, logic v, logic ill, logic fs, logic h);
    return {c, v, ill, fs, h};
  endfunction
  task automatic step(input int d, input string nm, input logic v, input logic [6:0] op,
                      input logic st, input logic fl, input exp_t e);
    exp_t x;
    logic [14:0] act;
    instr_valid = v;
    opcode = op;
    stall = st;
    flush = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    act = (d == 0) ? {a_ctrl, a_v, a_ill, a_fs, a_h} : {b_ctrl, b_v, b_ill, b_fs, b_h};
    checks++;
    if (act !== x) begin
      errors++;
      $display("FAIL %s dut%0d got ctrl=%b v=%b ill=%b fs=%b h=%b exp ctrl=%b v=%b ill=%b fs=%b h=%b",
               nm, d, act[14:4], act[3], act[2], act[1], act[0], x.c, x.v, x.ill, x.fs, x.h);
    end
  endtask
  task automatic do_reset(input int d);
    rst_n = 1'b0;
    step(d, "reset", 1'b1, O_R, 1'b0, 1'b0, ex('0, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask
  initial begin
    vecs = '{'{7'b0110011, C_R}, '{7'b0000011, C_LW}, '{7'b0100011, C_SW}, '{7'b1100011, C_BR},
             '{7'b0010011, C_I}, '{7'b0110111, C_LUI}, '{7'b1101111, C_JAL}, '{7'b1100111, C_JALR},
             '{7'b0010111, C_AU}};
    @(negedge clk);
    do_reset(0);
    for (int i = 0; i < 9; i++) step(0, "decode", 1'b1, vecs[i].op, 1'b0, 1'b0, ex(vecs[i].c, 1, 0, 0, 0));
    step(0, "no_valid", 1'b0, O_R, 1'b0, 1'b0, ex('0, 0, 0, 0, 0));
    step(0, "stall_issue", 1'b1, O_R, 1'b0, 1'b0, ex(C_R, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(0, "stall_hold", 1'b1, O_SW, 1'b1, 1'b0, ex(C_R, 1, 0, 0, 0));
    step(0, "stall_release", 1'b1, O_SW, 1'b0, 1'b0, ex(C_SW, 1, 0, 0, 0));
    step(0, "stall_flush", 1'b1, O_R, 1'b1, 1'b1, ex('0, 0, 0, 0, 0));
    step(0, "halt_flushed", 1'b1, O_HALT, 1'b0, 1'b1, ex('0, 0, 0, 0, 0));
    step(0, "after_flush", 1'b1, O_R, 1'b0, 1'b0, ex(C_R, 1, 0, 0, 0));
    step(0, "halt_stalled", 1'b1, O_HALT, 1'b1, 1'b0, ex(C_R, 1, 0, 0, 0));
    step(0, "ill_notrap", 1'b1, O_BAD, 1'b0, 1'b0, ex('0, 0, 1, 0, 0));
    step(0, "after_ill", 1'b1, O_I, 1'b0, 1'b0, ex(C_I, 1, 0, 0, 0));
    step(0, "halt_accept", 1'b1, O_HALT, 1'b0, 1'b0, ex('0, 0, 0, 1, 0));
    step(0, "drain1", 1'b1, O_R, 1'b0, 1'b0, ex('0, 0, 0, 1, 0));
    step(0, "drain2", 1'b1, O_R, 1'b0, 1'b0, ex('0, 0, 0, 1, 0));
    step(0, "halted", 1'b1, O_R, 1'b0, 1'b0, ex('0, 0, 0, 1, 1));
    step(0, "halted_ign", 1'b1, O_BAD, 1'b1, 1'b1, ex('0, 0, 0, 1, 1));
    step(0, "halted_ign2", 1'b1, O_I, 1'b0, 1'b0, ex('0, 0, 0, 1, 1));
    do_reset(0);
    step(0, "halt2", 1'b1, O_HALT, 1'b0, 1'b0, ex('0, 0, 0, 1, 0));
    step(0, "drain_cnt1", 1'b0, O_R, 1'b0, 1'b0, ex('0, 0, 0, 1, 0));
    rst_n = 1'b0;
    step(0, "reset_in_drain", 1'b1, O_I, 1'b0, 1'b0, ex('0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step(0, "post_reset", 1'b1, O_I, 1'b0, 1'b0, ex(C_I, 1, 0, 0, 0));
    do_reset(1);
    step(1, "b_ill_flushed", 1'b1, O_AU, 1'b0, 1'b1, ex('0, 0, 0, 0, 0));
    step(1, "b_r", 1'b1, O_R, 1'b0, 1'b0, ex(C_R, 1, 0, 0, 0));
    step(1, "b_ill_stalled", 1'b1, O_BAD, 1'b1, 1'b0, ex(C_R, 1, 0, 0, 0));
    step(1, "b_auipc_trap", 1'b1, O_AU, 1'b0, 1'b0, ex('0, 0, 1, 1, 0));
    step(1, "b_drain", 1'b1, O_R, 1'b0, 1'b0, ex('0, 0, 0, 1, 0));
    step(1, "b_halted", 1'b1, O_R, 1'b0, 1'b0, ex('0, 0, 0, 1, 1));
    do_reset(1);
    step(1, "b_bad_trap", 1'b1, O_BAD, 1'b0, 1'b0, ex('0, 0, 1, 1, 0));
    step(1, "b_bad_drain", 1'b1, O_BAD, 1'b0, 1'b0, ex('0, 0, 0, 1, 0));
    step(1, "b_bad_halted", 1'b1, O_R, 1'b0, 1'b0, ex('0, 0, 0, 1, 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
